// File: rtl/blink_sched_pkg.sv
// Shared types and width helpers for the blink code scheduler.
package blink_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } blink_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int clog2w(input int v);
    return (v > 2) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/blink_code_scheduler_if.sv
// Requester/LED bus of the blink code scheduler.
interface blink_code_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int CODE_W = 4
);
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ*CODE_W-1:0] i_code;
  logic [N_REQ-1:0]        o_grant;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_led;

  modport master (output i_req, i_code, input o_grant, o_busy, o_done, o_led);
  modport slave  (input i_req, i_code, output o_grant, o_busy, o_done, o_led);
endinterface

// File: rtl/blink_tick_gen.sv
// Tick prescaler: o_tick is high for one clock every TICK_DIV clocks; i_clr restarts the period.
module blink_tick_gen
  import blink_sched_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);
  localparam int CNT_W = clog2w(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                    cnt <= '0;
    else if (i_clr || cnt == LAST) cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign o_tick = (cnt == LAST);

endmodule

// File: rtl/blink_code_scheduler.sv
// Round-robin sharing of one status LED among N_REQ blink-code requesters.
// Optional: define BLINK_SCHED_ABORT_EN to cut a code short when its requester drops i_req.
module blink_code_scheduler
  import blink_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int CODE_W    = 4,
  parameter int TICK_DIV  = 25_000_000,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1,
  parameter int GAP_TICKS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  blink_code_scheduler_if.slave bus
);
  localparam int PTR_W = clog2w(N_REQ);
  localparam int DUR_W = clog2w(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);

  blink_state_e      state, state_n;
  logic [N_REQ-1:0]  grant, grant_n;
  logic              busy, busy_n, done, done_n, led, led_n;
  logic [PTR_W-1:0]  ptr, ptr_n;
  logic [CODE_W-1:0] blink_cnt, blink_cnt_n;
  logic [DUR_W-1:0]  dur, dur_last;
  logic              tick, clr, expire, abort;
  logic              pick_valid;
  logic [PTR_W-1:0]  pick_idx;
  logic [CODE_W-1:0] pick_code;
  logic [CODE_W-1:0] req_code [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_code
    assign req_code[k] = bus.i_code[k*CODE_W +: CODE_W];
  end

  blink_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (clr),
    .o_tick (tick)
  );

  // First active request after the last served one, wrapping.
  always_comb begin
    logic [PTR_W-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = ptr;
    cand       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!pick_valid && bus.i_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_code = req_code[pick_idx];

  always_comb begin
    dur_last = '0;
    unique case (state)
      S_ON:    dur_last = DUR_W'(ON_TICKS - 1);
      S_OFF:   dur_last = DUR_W'(OFF_TICKS - 1);
      S_GAP:   dur_last = DUR_W'(GAP_TICKS - 1);
      default: dur_last = '0;
    endcase
  end

  assign expire = tick && (dur == dur_last);

`ifdef BLINK_SCHED_ABORT_EN
  assign abort = (state == S_ON || state == S_OFF) && !(|(bus.i_req & grant));
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_n     = state;
    grant_n     = grant;
    busy_n      = busy;
    done_n      = 1'b0;
    led_n       = led;
    ptr_n       = ptr;
    blink_cnt_n = blink_cnt;
    unique case (state)
      S_IDLE: begin
        if (pick_valid) begin
          grant_n     = N_REQ'(1) << pick_idx;
          ptr_n       = pick_idx;
          blink_cnt_n = pick_code;
          busy_n      = 1'b1;
          if (pick_code != '0) begin
            state_n = S_ON;
            led_n   = 1'b1;
          end else begin
            state_n = S_GAP;
            led_n   = 1'b0;
          end
        end
      end
      S_ON: begin
        if (abort) begin
          state_n = S_GAP;
          led_n   = 1'b0;
        end else if (expire) begin
          state_n = S_OFF;
          led_n   = 1'b0;
        end
      end
      S_OFF: begin
        if (abort) begin
          state_n = S_GAP;
          led_n   = 1'b0;
        end else if (expire) begin
          blink_cnt_n = blink_cnt - 1'b1;
          if (blink_cnt_n != '0) begin
            state_n = S_ON;
            led_n   = 1'b1;
          end else begin
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (expire) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          grant_n = '0;
          busy_n  = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Every state entry restarts both the prescaler and the tick count.
  assign clr = (state_n != state);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      led       <= 1'b0;
      ptr       <= PTR_W'(N_REQ - 1);
      blink_cnt <= '0;
      dur       <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      busy      <= busy_n;
      done      <= done_n;
      led       <= led_n;
      ptr       <= ptr_n;
      blink_cnt <= blink_cnt_n;
      if (clr)                        dur <= '0;
      else if (tick && state != S_IDLE) dur <= dur + 1'b1;
    end
  end

  assign bus.o_grant = grant;
  assign bus.o_busy  = busy;
  assign bus.o_done  = done;
  assign bus.o_led   = led;

endmodule

// File: tb/tb_blink_code_scheduler.sv
// Self-checking bench for blink_code_scheduler against a transaction-level model.
module tb_blink_code_scheduler;
  localparam int N      = 4;
  localparam int CW     = 4;
  localparam int TD     = 4;
  localparam int ON     = 2;
  localparam int OFF    = 3;
  localparam int GAP    = 5;
  localparam int PERIOD = (ON + OFF) * TD;
`ifdef BLINK_SCHED_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   tests_run = 0;
  int   fails = 0;
  int   model_ptr = N - 1;
  int   codes [N];

  blink_code_scheduler_if #(.N_REQ(N), .CODE_W(CW)) bus ();

  blink_code_scheduler #(
    .N_REQ(N), .CODE_W(CW), .TICK_DIV(TD),
    .ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GAP)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
    $fatal(1, "watchdog");
  end

  function automatic int model_pick(input logic [N-1:0] req);
    for (int i = 1; i <= N; i++)
      if (req[(model_ptr + i) % N]) return (model_ptr + i) % N;
    return 0;
  endfunction

  // LED level t clocks after the grant edge for a code played in full.
  function automatic logic exp_led(input int code, input int t);
    return (t < code * PERIOD) && ((t % PERIOD) < ON * TD);
  endfunction

  task automatic set_code(input int k, input int v);
    codes[k] = v;
    bus.i_code[k*CW +: CW] = CW'(v);
  endtask

  task automatic do_reset;
    @(negedge i_clk);
    bus.i_req = '0;
    #2 i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    model_ptr = N - 1;
  endtask

  // Waits for the grant, then checks every clock of the service up to and including o_done.
  task automatic serve(input int idx, input int abort_k, input string name);
    int n, c, total;
    bit cut;
    logic [N+2:0] exp_v, got_v;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (bus.o_grant === '0 && n < 200);
    tests_run++;
    if (n != 1 || bus.o_grant !== N'(1 << idx)) begin
      fails++;
      $display("FAIL %s grant: got %b after %0d cycles, want %b after 1", name, bus.o_grant, n, N'(1 << idx));
    end
    if (bus.o_grant === '0) return;
    c     = codes[idx];
    cut   = ABORT_EN && abort_k >= 0 && abort_k < c * PERIOD;
    total = cut ? abort_k + 1 + GAP * TD : c * PERIOD + GAP * TD;
    for (int t = 0; t <= total; t++) begin
      if (t == total) exp_v = {N'(0), 1'b0, 1'b1, 1'b0};
      else            exp_v = {N'(1 << idx), 1'b1, 1'b0, (cut && t > abort_k) ? 1'b0 : exp_led(c, t)};
      got_v = {bus.o_grant, bus.o_busy, bus.o_done, bus.o_led};
      tests_run++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL %s t=%0d {grant,busy,done,led}: got %b want %b", name, t, got_v, exp_v);
      end
      if (t == abort_k) bus.i_req[idx] = 1'b0;
      if (t < total) @(negedge i_clk);
    end
    model_ptr = idx;
  endtask

  task automatic test_reset;
    bus.i_req  = '0;
    bus.i_code = '0;
    for (int k = 0; k < N; k++) codes[k] = 0;
    repeat (2) @(negedge i_clk);
    #2 i_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) #1;
      else        @(negedge i_clk);
      tests_run++;
      if ({bus.o_grant, bus.o_busy, bus.o_done, bus.o_led} !== '0) begin
        fails++;
        $display("FAIL reset_%0d: got grant=%b busy=%b done=%b led=%b, want all 0",
                 k, bus.o_grant, bus.o_busy, bus.o_done, bus.o_led);
      end
    end
    i_rst = 1'b0;
    model_ptr = N - 1;
  endtask

  task automatic test_single;
    set_code(0, 2);
    bus.i_req = 4'b0001;
    serve(model_pick(bus.i_req), -1, "single");
    bus.i_req = '0;
  endtask

  task automatic test_code_zero;
    @(negedge i_clk);
    set_code(2, 0);
    bus.i_req = 4'b0100;
    serve(model_pick(bus.i_req), -1, "code_zero");
    bus.i_req = '0;
  endtask

  task automatic test_round_robin;
    do_reset;
    for (int k = 0; k < N; k++) set_code(k, 1);
    bus.i_req = 4'b1111;
    for (int s = 0; s < 5; s++) serve(model_pick(bus.i_req), -1, "round_robin");
    bus.i_req = '0;
  endtask

  task automatic test_mid_reset;
    int n;
    do_reset;
    set_code(0, 2);
    bus.i_req = 4'b0001;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (bus.o_grant === '0 && n < 200);
    tests_run++;
    if (bus.o_grant !== 4'b0001) begin
      fails++;
      $display("FAIL mid_reset grant: got %b want 0001", bus.o_grant);
    end
    repeat (24) @(negedge i_clk);
    tests_run++;
    if (bus.o_led !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset second_on led: got %b want 1", bus.o_led);
    end
    #2 i_rst = 1'b1;
    bus.i_req = 4'b1010;
    set_code(1, $urandom_range(0, 2));
    set_code(3, $urandom_range(0, 2));
    model_ptr = N - 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) #1;
      else        @(negedge i_clk);
      tests_run++;
      if ({bus.o_grant, bus.o_busy, bus.o_done, bus.o_led} !== '0) begin
        fails++;
        $display("FAIL mid_reset hold_%0d: got grant=%b busy=%b done=%b led=%b, want all 0",
                 k, bus.o_grant, bus.o_busy, bus.o_done, bus.o_led);
      end
    end
    i_rst = 1'b0;
    serve(model_pick(bus.i_req), -1, "after_reset_first");
    bus.i_req = 4'b1000;
    serve(model_pick(bus.i_req), -1, "after_reset_second");
    bus.i_req = '0;
  endtask

  task automatic test_abort;
    @(negedge i_clk);
    set_code(2, 3);
    bus.i_req = 4'b0100;
    serve(model_pick(bus.i_req), 10, "abort");
    bus.i_req = '0;
  endtask

  task automatic test_random;
    logic [N-1:0] req;
    int idx;
    for (int it = 0; it < 8; it++) begin
      if (bus.i_req == '0) begin
        @(negedge i_clk);
        req = N'($urandom_range(1, (1 << N) - 1));
        for (int k = 0; k < N; k++)
          if (req[k]) set_code(k, $urandom_range(0, 3));
        bus.i_req = req;
      end
      idx = model_pick(bus.i_req);
      serve(idx, -1, "random");
      req = bus.i_req;
      if ($urandom_range(0, 1) == 1) req[idx] = 1'b0;
      for (int k = 0; k < N; k++)
        if (!req[k] && $urandom_range(0, 3) == 0) begin
          set_code(k, $urandom_range(0, 3));
          req[k] = 1'b1;
        end
      bus.i_req = req;
    end
    bus.i_req = '0;
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_code_zero;
    test_round_robin;
    test_mid_reset;
    test_abort;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/blink_code_scheduler.md
Name: blink_code_scheduler

Overview:
- Shares one status LED among N_REQ requesters; each requester asks for a blink code, i.e. a count of 0..15 flashes.
- Round-robin arbitration; one requester is served at a time.
- Each granted code plays as ON/OFF pulse pairs followed by an inter-code gap.
- Timing comes from a clock prescaler; the block sits beside the free-running blinker and drives the board LED.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- CODE_W, 4, bits per blink code
- TICK_DIV, 25_000_000, clocks per tick (>=1); default gives 0.25 s at 100 MHz
- ON_TICKS, 1, ticks LED is high per flash (>=1)
- OFF_TICKS, 1, ticks LED is low after each flash (>=1)
- GAP_TICKS, 8, ticks LED is low after the last flash (>=1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_req  in  N_REQ  request per requester; held high until o_done
- i_code  in  N_REQ*CODE_W  code of requester k at [k*CODE_W +: CODE_W]; must be stable while i_req[k] is high
- o_grant  out  N_REQ  one-hot; high for the whole service of the granted requester
- o_busy  out  1  high when not IDLE
- o_done  out  1  one-cycle pulse at end of service
- o_led  out  1  LED drive

Behaviour:
- Reset is decided: i_clk, i_rst asynchronous active-high.
- Reset values: o_grant=0, o_busy=0, o_done=0, o_led=0, state IDLE, rr pointer=N_REQ-1 (so req0 wins first). All outputs are registered.
- States: IDLE, ON, OFF, GAP.
- IDLE with any i_req high, at the next edge:
  - select the first requester searching from ptr+1 with wrap
  - set o_grant one-hot and ptr=index
  - latch code into blink_cnt
  - clear the prescaler and duration counter
  - go to ON (o_led=1) if code!=0, else go to GAP
- The prescaler is cleared on every state entry, so each state lasts exactly X_TICKS*TICK_DIV clocks.
- ON expiry -> OFF, o_led=0.
- OFF expiry:
  - blink_cnt-1 != 0 -> ON
  - else -> GAP
  - blink_cnt decrements on OFF expiry.
- GAP expiry -> IDLE. In the same edge: o_done=1 for one cycle, o_grant=0, o_busy=0.
- IDLE lasts at least 1 cycle; the earliest next grant is on the edge after o_done.
- Service time = code*(ON_TICKS+OFF_TICKS)*TICK_DIV + GAP_TICKS*TICK_DIV clocks, measured from the grant edge to the done edge.
- i_req changes during service are ignored, except as described under the optional feature.
- A requester still requesting after o_done competes again; rr fairness puts it last.
- Counter widths:
  - prescaler: $clog2(TICK_DIV)
  - duration: $clog2(max(ON,OFF,GAP)+1)
  - blink_cnt: CODE_W
  - No wrap-around is possible within these ranges.
- Asynchronous reset mid-service: all outputs drop immediately and ptr returns to N_REQ-1; no o_done is issued.

Optional Feature:
- Macro: BLINK_SCHED_ABORT_EN.
- Defined: if the granted requester's i_req falls while in ON or OFF:
  - next edge -> GAP with o_led=0
  - GAP plays fully, then o_done pulses as normal.
  - Falling i_req during GAP has no effect.
- Undefined: i_req is not monitored after grant; the full code always plays.

Decomposition:
- Package blink_sched_pkg:
  - state enum (IDLE/ON/OFF/GAP)
  - width helper function (max, clog2 wrapper)
- Sub-module blink_tick_gen:
  - TICK_DIV prescaler with synchronous clear input
  - one-cycle o_tick output
  - asynchronous reset

Test Plan:
Config: N_REQ=4, TICK_DIV=4, ON=2, OFF=3, GAP=5.
- Reset: assert i_rst mid-clock -> o_grant=0, o_led=0, o_busy=0 immediately; hold 3 cycles, all stay 0.
- Single request: i_req=0001, code0=2 -> o_grant=0001 next edge; o_led pattern 8 high, 12 low, 8 high, 12 low, 20 low; o_done pulses 60 clocks after grant edge, coincident with o_grant falling.
- Code 0: i_req=0100, code2=0 -> o_grant=0100; o_led stays 0; o_done 20 clocks after grant.
- Round robin: i_req=1111 held, all codes=1 -> grant order 0001, 0010, 0100, 1000, 0001; each service 40 clocks; 1 idle cycle between services.
- Mid-service reset: reset 5 clocks into second ON -> outputs 0 at once; after release, req1 and req3 high -> req1 granted first (ptr was reset).
- Abort (with BLINK_SCHED_ABORT_EN): code=3, drop i_req 3 clocks into the first OFF -> GAP next edge; o_done 20 clocks later. Without the macro, the full 3 flashes play.
